// File: rtl/spimaster.sv
// SPI mode-0 master (MSB first, SS active low) with a valid/ready word interface
// toward the host: one WIDTH-bit word out on MOSI and one in from MISO per frame.
module spimaster #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV   = 2,
    parameter int unsigned GUARD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] txdata,
    input  logic             txvalid,
    output logic             txready,
    output logic [WIDTH-1:0] rxdata,
    output logic             rxvalid,
    input  logic             rxready,
    output logic             busy,
    output logic             SCLK,
    output logic             SS,
    output logic             MOSI,
    input  logic             MISO
);

    localparam int unsigned CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg;

    assign txready = (state == IDLE) && !rxvalid;
    assign busy    = (state != IDLE);

    // The shift register moves on the rising SCLK edge so the received bit lands in the
    // LSB without clobbering transmit bits; the falling edge then exposes the new MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            rxdata  <= '0;
            rxvalid <= 1'b0;
            SCLK    <= 1'b0;
            SS      <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            if (rxvalid && rxready) begin
                rxvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (txvalid && txready) begin
                        shreg  <= txdata;
                        MOSI   <= txdata[WIDTH-1];
                        SS     <= 1'b0;
                        cnt    <= '0;
                        bitcnt <= '0;
                        state  <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        if (!SCLK) begin
                            SCLK  <= 1'b1;
                            shreg <= {shreg[WIDTH-2:0], MISO};
                        end else begin
                            SCLK <= 1'b0;
                            if (bitcnt == BIT_LAST) begin
                                state <= HOLD;
                            end else begin
                                bitcnt <= bitcnt + BW'(1);
                                MOSI   <= shreg[WIDTH-1];
                            end
                        end
                    end
                end

                HOLD: begin
                    if (cnt == GUARD_LAST) begin
                        cnt     <= '0;
                        SS      <= 1'b1;
                        MOSI    <= 1'b0;
                        rxdata  <= shreg;
                        rxvalid <= 1'b1;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                GAP: begin
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spimaster.sv
// Scoreboard bench for spimaster: default instance (DIV=2, GUARD=1) plus a
// DIV=3, GUARD=2 instance for the slower frame timing.
module tb_spimaster;

    localparam int unsigned W       = 16;
    localparam int unsigned DA      = 2;
    localparam int unsigned GA      = 1;
    localparam int unsigned DB      = 3;
    localparam int unsigned GB      = 2;
    localparam int unsigned SSLOW_A = 2*GA + 2*DA*W;
    localparam int unsigned SSLOW_B = 2*GB + 2*DB*W;

    typedef struct packed {
        logic [W-1:0] tx;
        logic [W-1:0] rx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] txdata_a  = '0;
    logic         txvalid_a = 1'b0;
    logic         rxready_a = 1'b0;
    logic [W-1:0] rxdata_a;
    logic         txready_a, rxvalid_a, busy_a, sclk_a, ss_a, mosi_a, miso_a;

    logic [W-1:0] txdata_b  = '0;
    logic         txvalid_b = 1'b0;
    logic         rxready_b = 1'b1;
    logic [W-1:0] rxdata_b;
    logic         txready_b, rxvalid_b, busy_b, sclk_b, ss_b, mosi_b, miso_b;

    exp_t expq[$];
    exp_t expq_b[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spimaster #(.WIDTH(W), .DIV(DA), .GUARD(GA)) dut_a (
        .clk(clk), .rst(rst),
        .txdata(txdata_a), .txvalid(txvalid_a), .txready(txready_a),
        .rxdata(rxdata_a), .rxvalid(rxvalid_a), .rxready(rxready_a),
        .busy(busy_a), .SCLK(sclk_a), .SS(ss_a), .MOSI(mosi_a), .MISO(miso_a)
    );

    spimaster #(.WIDTH(W), .DIV(DB), .GUARD(GB)) dut_b (
        .clk(clk), .rst(rst),
        .txdata(txdata_b), .txvalid(txvalid_b), .txready(txready_b),
        .rxdata(rxdata_b), .rxvalid(rxvalid_b), .rxready(rxready_b),
        .busy(busy_b), .SCLK(sclk_b), .SS(ss_b), .MOSI(mosi_b), .MISO(miso_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Slave for instance A: loopback, or a preloaded word shifted out MSB first
    logic         loopback = 1'b1;
    logic [W-1:0] sload    = '0;
    logic [W-1:0] sreg     = '0;
    logic         s_pss    = 1'b1;
    logic         s_psclk  = 1'b0;

    assign miso_a = loopback ? mosi_a : sreg[W-1];
    assign miso_b = mosi_b;

    always @(negedge clk) begin
        if (!ss_a && s_pss) sreg = sload;
        else if (!ss_a && !sclk_a && s_psclk) sreg = sreg << 1;
        s_pss   = ss_a;
        s_psclk = sclk_a;
    end

    // Instance A monitor: frame length, SCLK edge count, MOSI stream, rx scoreboard
    int unsigned  a_low   = 0;
    int unsigned  a_rises = 0;
    logic [W-1:0] a_cap   = '0;
    logic         a_mosi_or = 1'b0;
    logic         a_pss   = 1'b1;
    logic         a_psclk = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            a_low = 0; a_rises = 0; a_cap = '0; a_mosi_or = 1'b0;
            a_pss = 1'b1; a_psclk = 1'b0;
        end else begin
            if (!ss_a) begin
                a_low++;
                a_mosi_or = a_mosi_or | mosi_a;
            end
            if (sclk_a && !a_psclk) begin
                if (a_rises == 0) chk("a_first_rise", 32'(a_low), 32'(GA + DA + 1));
                a_rises++;
                a_cap = {a_cap[W-2:0], mosi_a};
            end
            if (ss_a && !a_pss) begin
                chk("a_ss_low", 32'(a_low), 32'(SSLOW_A));
                chk("a_rises", 32'(a_rises), 32'(W));
                chk("a_frame_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    chk("a_mosi", 32'(a_cap), 32'(expq[0].tx));
                    chk("a_mosi_any", 32'(a_mosi_or), 32'(expq[0].tx != '0));
                end
                a_low = 0; a_rises = 0; a_cap = '0; a_mosi_or = 1'b0;
            end
            if (rxvalid_a && rxready_a) begin
                chk("a_rx_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("a_rxdata", 32'(rxdata_a), 32'(e.rx));
                end
            end
            a_pss   = ss_a;
            a_psclk = sclk_a;
        end
    end

    // Instance B monitor: SCLK phase lengths, SS low length, SS high gap, rx scoreboard
    int unsigned b_low = 0, b_hi = 0, b_lo = 0, b_gap = 0, b_frames = 0;
    logic        b_pss = 1'b1, b_psclk = 1'b0, b_after_fall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            b_low = 0; b_hi = 0; b_lo = 0; b_gap = 0; b_frames = 0;
            b_pss = 1'b1; b_psclk = 1'b0; b_after_fall = 1'b0;
        end else begin
            if (!ss_b && b_pss) begin
                if (b_frames > 0) chk("b_gap_min", 32'(b_gap >= GB), 32'd1);
                b_after_fall = 1'b0; b_lo = 0; b_low = 0;
            end
            if (ss_b && !b_pss) begin
                chk("b_ss_low", 32'(b_low), 32'(SSLOW_B));
                b_frames++;
                b_gap = 0;
            end
            if (!ss_b) b_low++;
            else b_gap++;
            if (sclk_b && !b_psclk) begin
                if (b_after_fall) chk("b_sclk_low", 32'(b_lo), 32'(DB));
                b_hi = 1; b_lo = 0;
            end else if (!sclk_b && b_psclk) begin
                chk("b_sclk_high", 32'(b_hi), 32'(DB));
                b_lo = 1; b_hi = 0; b_after_fall = 1'b1;
            end else if (sclk_b) begin
                b_hi++;
            end else begin
                b_lo++;
            end
            if (rxvalid_b && rxready_b) begin
                chk("b_rx_expected", 32'(expq_b.size() > 0), 32'd1);
                if (expq_b.size() > 0) begin
                    e = expq_b.pop_front();
                    chk("b_rxdata", 32'(rxdata_b), 32'(e.rx));
                end
            end
            b_pss   = ss_b;
            b_psclk = sclk_b;
        end
    end

    task automatic send_a(input logic [W-1:0] d, input logic [W-1:0] rx);
        int   n = 0;
        exp_t e;
        txdata_a  = d;
        txvalid_a = 1'b1;
        while (!txready_a && n < 300) begin
            tick(1);
            n++;
        end
        chk("a_accept_wait", 32'(n < 300), 32'd1);
        e.tx = d;
        e.rx = rx;
        expq.push_back(e);
        tick(1);
        txvalid_a = 1'b0;
        chk("a_ss_fall", 32'(ss_a), 32'd0);
        chk("a_busy", 32'(busy_a), 32'd1);
    endtask

    task automatic send_b(input logic [W-1:0] d);
        int   n = 0;
        exp_t e;
        txdata_b  = d;
        txvalid_b = 1'b1;
        while (!txready_b && n < 400) begin
            tick(1);
            n++;
        end
        chk("b_accept_wait", 32'(n < 400), 32'd1);
        e.tx = d;
        e.rx = d;
        expq_b.push_back(e);
        tick(1);
        chk("b_ss_fall", 32'(ss_b), 32'd0);
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("a_drain", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int   n;
        logic seen;

        // Reset state
        rst = 1'b1;
        tick(2);
        chk("rst_ss", 32'(ss_a), 32'd1);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        chk("rst_rxvalid", 32'(rxvalid_a), 32'd0);
        chk("rst_rxdata", 32'(rxdata_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_txready", 32'(txready_a), 32'd1);
        rst = 1'b0;
        tick(1);
        chk("post_rst_txready", 32'(txready_a), 32'd1);
        chk("post_rst_ss", 32'(ss_a), 32'd1);

        // Loopback frame, host not yet consuming
        loopback  = 1'b1;
        rxready_a = 1'b0;
        send_a(16'hA53C, 16'hA53C);
        n = 0;
        while (!rxvalid_a && n < 300) begin
            tick(1);
            n++;
        end
        chk("f1_done", 32'(n < 300), 32'd1);
        chk("f1_rxvalid", 32'(rxvalid_a), 32'd1);
        chk("f1_rxdata", 32'(rxdata_a), 32'hA53C);

        // Backpressure: pending rx word blocks the next frame
        txdata_a  = 16'h5AC3;
        txvalid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_txready", 32'(txready_a), 32'd0);
            chk("hold_ss", 32'(ss_a), 32'd1);
            chk("hold_rxdata", 32'(rxdata_a), 32'hA53C);
        end
        begin
            exp_t e;
            e.tx = 16'h5AC3;
            e.rx = 16'h5AC3;
            expq.push_back(e);
        end
        rxready_a = 1'b1;
        tick(1);
        chk("rel_rxvalid", 32'(rxvalid_a), 32'd0);
        chk("rel_txready", 32'(txready_a), 32'd1);
        tick(1);
        chk("f2_ss_fall", 32'(ss_a), 32'd0);
        txvalid_a = 1'b0;
        drain_a(300);

        // Slave returns 0x8001 while master sends zeros
        loopback = 1'b0;
        sload    = 16'h8001;
        send_a(16'h0000, 16'h8001);
        drain_a(300);

        // Reset during bit 7 abandons the frame
        loopback = 1'b1;
        send_a(16'hFFFF, 16'hFFFF);
        n = 0;
        while (a_rises < 8 && n < 200) begin
            tick(1);
            n++;
        end
        chk("a_reach_bit7", 32'(n < 200), 32'd1);
        chk("bit7_mosi", 32'(mosi_a), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ss", 32'(ss_a), 32'd1);
        chk("mid_rst_sclk", 32'(sclk_a), 32'd0);
        chk("mid_rst_mosi", 32'(mosi_a), 32'd0);
        chk("mid_rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        expq.delete();
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            seen = seen | rxvalid_a;
        end
        chk("abandon_rxvalid", 32'(seen), 32'd0);
        send_a(16'h1234, 16'h1234);
        drain_a(300);

        // Slower instance: back-to-back frames
        send_b(16'hC3A5);
        send_b(16'h0F0F);
        txvalid_b = 1'b0;
        n = 0;
        while (expq_b.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        chk("b_drain", 32'(n < 500), 32'd1);
        tick(4);
        chk("b_frames", 32'(b_frames), 32'd2);
        chk("a_q_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
